// File: rtl/regfile_port_sequencer_pkg.sv
// rtl/regfile_port_sequencer_pkg.sv - shared encodings and widths for the register-bank port sequencer
package regfile_port_sequencer_pkg;

    // Default widths, matching register_bank data_in/data_out and addr.
    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_RSP  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    // Which requester wins when both are valid in the same IDLE cycle.
    typedef enum logic {
        PRIO_WB  = 1'b0,
        PRIO_REQ = 1'b1
    } prio_t;

endpackage

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - alternating-priority grant between writeback and operand-read requesters
//
// Ports:
//   clk, rst_n            clock, async active-low reset (prio returns to PRIO_WB)
//   enable                high only while the sequencer is IDLE; all readies are 0 otherwise
//   wb_valid, req_valid   requester valids
//   wb_ready, req_ready   requester readies
//   wb_grant, req_grant   handshake completes this cycle (mutually exclusive)
module regfile_port_arbiter
    import regfile_port_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic wb_valid,
    input  logic req_valid,
    output logic wb_ready,
    output logic req_ready,
    output logic wb_grant,
    output logic req_grant
);

    prio_t prio;

    // When both are valid only the prio holder sees ready, so the grants can
    // never fire together; a lone requester is always served.
    assign wb_ready  = enable && (!req_valid || (prio == PRIO_WB));
    assign req_ready = enable && (!wb_valid  || (prio == PRIO_REQ));
    assign wb_grant  = wb_valid  && wb_ready;
    assign req_grant = req_valid && req_ready;

    // Every grant hands priority to the other side, so a losing requester
    // is guaranteed the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PRIO_WB;
        end else if (wb_grant) begin
            prio <= PRIO_REQ;
        end else if (req_grant) begin
            prio <= PRIO_WB;
        end
    end

endmodule

// File: rtl/regfile_port_sequencer.sv
// rtl/regfile_port_sequencer.sv - shares a single-port register bank between operand reads and writeback
//
// Ports:
//   clk, rst_n                      clock shared with register_bank, async active-low reset
//   req_valid/req_ready             operand-read request handshake (req_rs1, req_rs2)
//   rsp_valid/rsp_ready             operand response handshake (rsp_rs1_data, rsp_rs2_data)
//   wb_valid/wb_ready               writeback handshake (wb_addr, wb_data)
//   bank_addr/bank_wdata/bank_write to register_bank; bank_rdata is combinational from bank_addr
//   busy                            high whenever the sequencer is not IDLE
module regfile_port_sequencer
    import regfile_port_sequencer_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rs1_data,
    output logic [DATA_W-1:0] rsp_rs2_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    output logic              bank_write,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_grant;
    logic              req_grant;

    regfile_port_arbiter u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (state == ST_IDLE),
        .wb_valid  (wb_valid),
        .req_valid (req_valid),
        .wb_ready  (wb_ready),
        .req_ready (req_ready),
        .wb_grant  (wb_grant),
        .req_grant (req_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb_grant) begin
                        wb_addr_q <= wb_addr;
                        wb_data_q <= wb_data;
                        state     <= ST_WB;
                    end else if (req_grant) begin
                        rs1_q <= req_rs1;
                        rs2_q <= req_rs2;
                        state <= ST_RD1;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                ST_RD1: begin
                    rsp_rs1_data <= bank_rdata;
                    state        <= ST_RD2;
                end
                ST_RD2: begin
                    rsp_rs2_data <= bank_rdata;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank signals follow the state directly, so an async reset drops
    // bank_write before the next edge and an in-flight write is abandoned.
    always_comb begin
        bank_addr  = '0;
        bank_wdata = '0;
        bank_write = 1'b0;
        case (state)
            ST_WB: begin
                bank_addr  = wb_addr_q;
                bank_wdata = wb_data_q;
                bank_write = 1'b1;
            end
            ST_RD1:  bank_addr = rs1_q;
            ST_RD2:  bank_addr = rs2_q;
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb/tb_regfile_port_sequencer.sv - self-checking bench for regfile_port_sequencer
module tb_regfile_port_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_rs1;
    logic [4:0] req_rs2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rs1_data;
    logic [7:0] rsp_rs2_data;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_addr;
    logic [7:0] wb_data;
    logic [4:0] bank_addr;
    logic [7:0] bank_wdata;
    logic       bank_write;
    logic [7:0] bank_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Register bank the DUT drives, and the bench's transaction-level view of it.
    logic [7:0] bank_mem [32];
    logic [7:0] ref_mem  [32];
    // Whoever was granted last loses the next contention; reset favours writeback.
    logic       last_was_wb;

    regfile_port_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rs1_data (rsp_rs1_data),
        .rsp_rs2_data (rsp_rs2_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_write   (bank_write),
        .bank_rdata   (bank_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_write) bank_mem[bank_addr] <= bank_wdata;
    end
    assign bank_rdata = bank_mem[bank_addr];

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_was_wb = 1'b0;
    endtask

    // Waits for wb_ready with wb_valid already driven, then retires the write.
    task automatic wb_wait_accept();
        int n = 0;
        #1;
        while (!wb_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!wb_ready) begin
            bad++;
            $display("FAIL wb_accept_timeout: wb_ready=%b required 1", wb_ready);
        end
        ref_mem[wb_addr] = wb_data;
        @(negedge clk);
        wb_valid = 1'b0;
        last_was_wb = 1'b1;
    endtask

    task automatic wb_issue(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        wb_wait_accept();
    endtask

    // Returns at the negedge following acceptance (the RD1 cycle).
    task automatic rd_issue(input logic [4:0] a1, input logic [4:0] a2);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = a1;
        req_rs2   = a2;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        last_was_wb = 1'b0;
    endtask

    task automatic rd_collect(output logic [7:0] d1, output logic [7:0] d2);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 50);
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        d1 = rsp_rs1_data;
        d2 = rsp_rs2_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_rs1_data !== 8'h00 || rsp_rs2_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp: valid=%b d1=%h d2=%h required 0 00 00", rsp_valid, rsp_rs1_data, rsp_rs2_data);
        end
        total++;
        if (bank_write !== 1'b0 || bank_addr !== 5'd0 || bank_wdata !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_bank: write=%b addr=%h wdata=%h busy=%b required 0 00 00 0", bank_write, bank_addr, bank_wdata, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_was_wb = 1'b0;
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 8'h04;
        #1;
        total++;
        if (wb_ready !== 1'b1) begin
            bad++; $display("FAIL wtr_wb_ready: got %b required 1", wb_ready);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        total++;
        if (bank_write !== 1'b1 || bank_addr !== 5'd4 || bank_wdata !== 8'h04) begin
            bad++; $display("FAIL wtr_wb_drive: write=%b addr=%h wdata=%h required 1 04 04", bank_write, bank_addr, bank_wdata);
        end
        ref_mem[4] = 8'h04;
        last_was_wb = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (bank_mem[4] !== 8'h04 || bank_write !== 1'b0) begin
            bad++; $display("FAIL wtr_wb_commit: reg4=%h write=%b required 04 0", bank_mem[4], bank_write);
        end
        req_valid = 1'b1; req_rs1 = 5'd4; req_rs2 = 5'd1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL wtr_req_ready: got %b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        last_was_wb = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || bank_addr !== 5'd4) begin
            bad++; $display("FAIL wtr_rd1: rsp_valid=%b busy=%b addr=%h required 0 1 04", rsp_valid, busy, bank_addr);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || bank_addr !== 5'd1) begin
            bad++; $display("FAIL wtr_rd2: rsp_valid=%b addr=%h required 0 01", rsp_valid, bank_addr);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_rs1_data !== ref_mem[4] || rsp_rs2_data !== ref_mem[1]) begin
            bad++; $display("FAIL wtr_rsp: valid=%b d1=%h d2=%h required 1 %h %h", rsp_valid, rsp_rs1_data, rsp_rs2_data, ref_mem[4], ref_mem[1]);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL wtr_idle: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d1, d2;
        pulse_reset();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 8'hAA;
        req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7;
        #1;
        total++;
        if (wb_ready !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL sim_first_grant: wb_ready=%b req_ready=%b required 1 0", wb_ready, req_ready);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        ref_mem[7] = 8'hAA;
        #1;
        total++;
        if (bank_write !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL sim_wb_cycle: write=%b req_ready=%b required 1 0", bank_write, req_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL sim_second_grant: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        last_was_wb = 1'b0;
        rd_collect(d1, d2);
        total++;
        if (d1 !== ref_mem[7] || d2 !== ref_mem[7]) begin
            bad++; $display("FAIL sim_rsp: d1=%h d2=%h required %h %h", d1, d2, ref_mem[7], ref_mem[7]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp1 [$];
        logic [7:0] exp2 [$];
        logic gw, gr, exp_wb;
        int grants = 0;
        int cyc = 0;
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'($urandom); wb_data = 8'($urandom);
        req_valid = 1'b1; req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
        while ((grants < 4 || exp1.size() > 0) && cyc < 100) begin
            #1;
            cyc++;
            gw = wb_valid && wb_ready;
            gr = req_valid && req_ready;
            if (rsp_valid) begin
                total++;
                if (exp1.size() == 0) begin
                    bad++; $display("FAIL b2b_rsp_unexpected: rsp_valid=%b required 0", rsp_valid);
                end else begin
                    if (rsp_rs1_data !== exp1[0] || rsp_rs2_data !== exp2[0]) begin
                        bad++; $display("FAIL b2b_rsp_data: d1=%h d2=%h required %h %h", rsp_rs1_data, rsp_rs2_data, exp1[0], exp2[0]);
                    end
                    void'(exp1.pop_front());
                    void'(exp2.pop_front());
                end
            end
            if (gw || gr) begin
                exp_wb = !last_was_wb;
                total++;
                if (gw !== exp_wb || (gw && gr)) begin
                    bad++; $display("FAIL b2b_grant_order: grant %0d wb=%b req=%b required wb=%b", grants, gw, gr, exp_wb);
                end
                if (gw) begin
                    ref_mem[wb_addr] = wb_data;
                end else begin
                    exp1.push_back(ref_mem[req_rs1]);
                    exp2.push_back(ref_mem[req_rs2]);
                end
                last_was_wb = gw;
                grants++;
            end
            @(posedge clk);
            #1;
            if (gw) begin wb_addr = 5'($urandom); wb_data = 8'($urandom); end
            if (gr) begin req_rs1 = 5'($urandom); req_rs2 = 5'($urandom); end
            if (grants >= 4) begin wb_valid = 1'b0; req_valid = 1'b0; end
            @(negedge clk);
        end
        total++;
        if (grants < 4 || exp1.size() != 0) begin
            bad++; $display("FAIL b2b_timeout: grants=%0d pending=%0d required 4 0", grants, exp1.size());
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] a1, a2, wa;
        logic [7:0] e1, e2, wd;
        int n = 0;
        a1 = 5'($urandom); a2 = 5'($urandom);
        wa = 5'($urandom); wd = 8'($urandom);
        e1 = ref_mem[a1]; e2 = ref_mem[a2];
        rsp_ready = 1'b0;
        rd_issue(a1, a2);
        #1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin wb_valid = 1'b1; wb_addr = wa; wb_data = wd; end
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rs1_data !== e1 || rsp_rs2_data !== e2 || wb_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%b d1=%h d2=%h wb_ready=%b busy=%b required 1 %h %h 0 1",
                                i, rsp_valid, rsp_rs1_data, rsp_rs2_data, wb_ready, busy, e1, e2);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || wb_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: busy=%b rsp_valid=%b wb_ready=%b required 0 0 1", busy, rsp_valid, wb_ready);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        total++;
        if (bank_write !== 1'b1 || bank_addr !== wa || bank_wdata !== wd) begin
            bad++; $display("FAIL bp_wb_grant: write=%b addr=%h wdata=%h required 1 %h %h", bank_write, bank_addr, bank_wdata, wa, wd);
        end
        ref_mem[wa] = wd;
        last_was_wb = 1'b1;
    endtask

    task automatic test_reset_during_wb();
        logic [4:0] a;
        logic [7:0] d1, d2;
        a = 5'($urandom);
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = a; wb_data = ~ref_mem[a];
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        total++;
        if (bank_write !== 1'b1) begin
            bad++; $display("FAIL rst_wb_enter: write=%b required 1", bank_write);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bank_write !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || bank_addr !== 5'd0 || bank_wdata !== 8'h00) begin
            bad++; $display("FAIL rst_wb_drop: write=%b busy=%b rsp_valid=%b addr=%h wdata=%h required 0 0 0 00 00",
                            bank_write, busy, rsp_valid, bank_addr, bank_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_was_wb = 1'b0;
        rd_issue(a, a);
        rd_collect(d1, d2);
        total++;
        if (d1 !== ref_mem[a] || d2 !== ref_mem[a]) begin
            bad++; $display("FAIL rst_wb_nocommit: d1=%h d2=%h required %h %h", d1, d2, ref_mem[a], ref_mem[a]);
        end
    endtask

    task automatic test_write_during_read();
        logic [7:0] e1, e2, d1, d2;
        e1 = ref_mem[2];
        e2 = ref_mem[3];
        rd_issue(5'd2, 5'd3);
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 8'h55;
        #1;
        total++;
        if (wb_ready !== 1'b0) begin
            bad++; $display("FAIL wdr_wb_blocked: wb_ready=%b required 0", wb_ready);
        end
        rd_collect(d1, d2);
        total++;
        if (d1 !== e1 || d2 !== e2) begin
            bad++; $display("FAIL wdr_old_value: d1=%h d2=%h required %h %h", d1, d2, e1, e2);
        end
        wb_wait_accept();
        rd_issue(5'd2, 5'd2);
        rd_collect(d1, d2);
        total++;
        if (d1 !== 8'h55 || d2 !== 8'h55) begin
            bad++; $display("FAIL wdr_new_value: d1=%h d2=%h required 55 55", d1, d2);
        end
    endtask

    task automatic test_random_traffic();
        logic [4:0] a1, a2;
        logic [7:0] d1, d2, e1, e2;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                wb_issue(5'($urandom), 8'($urandom));
            end
            a1 = 5'($urandom); a2 = 5'($urandom);
            e1 = ref_mem[a1]; e2 = ref_mem[a2];
            rd_issue(a1, a2);
            rd_collect(d1, d2);
            total++;
            if (d1 !== e1 || d2 !== e2) begin
                bad++; $display("FAIL rand_read[%0d]: d1=%h d2=%h required %h %h", i, d1, d2, e1, e2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            bank_mem[i] = 8'(i);
            ref_mem[i]  = 8'(i);
        end
        rst_n = 1'b0;
        req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        last_was_wb = 1'b0;

        test_reset();
        test_write_then_read();
        test_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_reset_during_wb();
        test_write_during_read();
        test_random_traffic();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
